// File: rtl/axi_lite_reg4_slave_if.sv
// -----------------------------------------------------------------------------
// axi_lite_reg4_slave_if
// AXI4-Lite bus bundle (AW, W, B, AR and R channels) for the four-register
// control slave.
//   slave  modport : address/data/valid/ready-back inputs, ready/response outputs
//   master modport : the mirror image, for whatever drives the bus
// The clock and reset are not part of the bundle; they stay plain ports.
// -----------------------------------------------------------------------------
interface axi_lite_reg4_slave_if #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
);

   // Write address channel
   logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
   logic [2:0]                        S_AXI_AWPROT;
   logic                              S_AXI_AWVALID;
   logic                              S_AXI_AWREADY;
   // Write data channel
   logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
   logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
   logic                              S_AXI_WVALID;
   logic                              S_AXI_WREADY;
   // Write response channel
   logic [1:0]                        S_AXI_BRESP;
   logic                              S_AXI_BVALID;
   logic                              S_AXI_BREADY;
   // Read address channel
   logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
   logic [2:0]                        S_AXI_ARPROT;
   logic                              S_AXI_ARVALID;
   logic                              S_AXI_ARREADY;
   // Read data channel
   logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
   logic [1:0]                        S_AXI_RRESP;
   logic                              S_AXI_RVALID;
   logic                              S_AXI_RREADY;

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      input  S_AXI_RREADY
   );

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      output S_AXI_RREADY
   );

endinterface

// File: rtl/axi_lite_reg4_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_reg4_slave
// AXI4-Lite slave with four 32-bit read/write control registers at byte offsets
// 0x0/0x4/0x8/0xC. Register contents are driven out to fabric logic. Supports
// byte strobes, independent AW/W arrival, and one outstanding write plus one
// outstanding read.
// Ports:
//   S_AXI_ACLK     in   single clock
//   S_AXI_ARESETN  in   asynchronous active-low reset
//   s_axi          slave modport of the AXI4-Lite bundle
//   REGS_O         out  {reg3, reg2, reg1, reg0}
//   WR_PULSE_O     out  bit n high for one cycle after reg n is committed
// -----------------------------------------------------------------------------
module axi_lite_reg4_slave #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESETN,
   axi_lite_reg4_slave_if.slave              s_axi,
   output logic [4*C_S_AXI_DATA_WIDTH-1:0]   REGS_O,
   output logic [3:0]                        WR_PULSE_O
);

   localparam int unsigned NumBytes = C_S_AXI_DATA_WIDTH / 8;
   localparam int unsigned SelMsb   = C_S_AXI_ADDR_WIDTH - 1;

   // Holding state
   logic                            r_rst_done;
   logic                            r_aw_full;
   logic [1:0]                      r_aw_sel;
   logic                            r_w_full;
   logic [C_S_AXI_DATA_WIDTH-1:0]   r_wdata;
   logic [NumBytes-1:0]             r_wstrb;
   logic                            r_bvalid;
   logic                            r_rvalid;
   logic [C_S_AXI_DATA_WIDTH-1:0]   r_rdata;
   logic [C_S_AXI_DATA_WIDTH-1:0]   r_regs [4];
   logic [3:0]                      r_wr_pulse;

   logic                            w_awready;
   logic                            w_wready;
   logic                            w_arready;
   logic                            w_aw_hs;
   logic                            w_w_hs;
   logic                            w_ar_hs;
   logic                            w_commit;
   logic [1:0]                      w_sel;
   logic [1:0]                      w_rd_sel;
   logic [C_S_AXI_DATA_WIDTH-1:0]   w_data;
   logic [NumBytes-1:0]             w_strb;
   logic [C_S_AXI_DATA_WIDTH-1:0]   w_merged;
   logic                            w_unused;

   // Readies come only from registered state, so there is no valid->ready path.
   assign w_awready = r_rst_done & ~r_aw_full & ~r_bvalid;
   assign w_wready  = r_rst_done & ~r_w_full  & ~r_bvalid;
   assign w_arready = r_rst_done & ~r_rvalid;

   assign w_aw_hs = s_axi.S_AXI_AWVALID & w_awready;
   assign w_w_hs  = s_axi.S_AXI_WVALID  & w_wready;
   assign w_ar_hs = s_axi.S_AXI_ARVALID & w_arready;

   // Commit as soon as both halves are either held or arriving this edge.
   assign w_commit = (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs) & ~r_bvalid;

   // Prefer the held copy; otherwise take what is on the bus this edge.
   assign w_sel    = r_aw_full ? r_aw_sel : s_axi.S_AXI_AWADDR[SelMsb:2];
   assign w_data   = r_w_full  ? r_wdata  : s_axi.S_AXI_WDATA;
   assign w_strb   = r_w_full  ? r_wstrb  : s_axi.S_AXI_WSTRB;
   assign w_rd_sel = s_axi.S_AXI_ARADDR[SelMsb:2];

   always_comb begin
      w_merged = r_regs[w_sel];
      for (int k = 0; k < int'(NumBytes); k++) begin
         if (w_strb[k]) begin
            w_merged[8*k +: 8] = w_data[8*k +: 8];
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_rst_done <= 1'b0;
         r_aw_full  <= 1'b0;
         r_aw_sel   <= '0;
         r_w_full   <= 1'b0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_bvalid   <= 1'b0;
         r_rvalid   <= 1'b0;
         r_rdata    <= '0;
         r_wr_pulse <= '0;
         for (int i = 0; i < 4; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         r_rst_done <= 1'b1;
         r_wr_pulse <= '0;

         if (w_commit) begin
            r_regs[w_sel]     <= w_merged;
            r_wr_pulse[w_sel] <= 1'b1;
            r_bvalid          <= 1'b1;
            r_aw_full         <= 1'b0;
            r_w_full          <= 1'b0;
         end else begin
            if (w_aw_hs) begin
               r_aw_full <= 1'b1;
               r_aw_sel  <= s_axi.S_AXI_AWADDR[SelMsb:2];
            end
            if (w_w_hs) begin
               r_w_full <= 1'b1;
               r_wdata  <= s_axi.S_AXI_WDATA;
               r_wstrb  <= s_axi.S_AXI_WSTRB;
            end
            if (r_bvalid && s_axi.S_AXI_BREADY) begin
               r_bvalid <= 1'b0;
            end
         end

         // Read samples the pre-write register value when both land on one edge.
         if (w_ar_hs) begin
            r_rdata  <= r_regs[w_rd_sel];
            r_rvalid <= 1'b1;
         end else if (r_rvalid && s_axi.S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   assign s_axi.S_AXI_AWREADY = w_awready;
   assign s_axi.S_AXI_WREADY  = w_wready;
   assign s_axi.S_AXI_ARREADY = w_arready;
   assign s_axi.S_AXI_BVALID  = r_bvalid;
   assign s_axi.S_AXI_BRESP   = 2'b00;
   assign s_axi.S_AXI_RVALID  = r_rvalid;
   assign s_axi.S_AXI_RDATA   = r_rdata;
   assign s_axi.S_AXI_RRESP   = 2'b00;

   assign REGS_O     = {r_regs[3], r_regs[2], r_regs[1], r_regs[0]};
   assign WR_PULSE_O = r_wr_pulse;

   // Protection bits and sub-word address bits carry no meaning here.
   assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axi_lite_reg4_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_reg4_slave
// Directed bench for axi_lite_reg4_slave. Inputs change 1 time unit after the
// rising edge; outputs are sampled at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_axi_lite_reg4_slave;

   logic clk;
   logic rst_n;
   logic [127:0] regs;
   logic [3:0]   pulse;
   int n_checks;
   int n_errors;

   axi_lite_reg4_slave_if u_if ();

   axi_lite_reg4_slave u_dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .s_axi         (u_if),
      .REGS_O        (regs),
      .WR_PULSE_O    (pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input string tag, input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      int   t;
      logic aw_hs;
      logic w_hs;
      logic [3:0] exp_pulse;
      exp_pulse = 4'b0001 << a[3:2];
      u_if.S_AXI_AWADDR  = a;
      u_if.S_AXI_WDATA   = d;
      u_if.S_AXI_WSTRB   = s;
      u_if.S_AXI_AWVALID = 1'b1;
      u_if.S_AXI_WVALID  = 1'b1;
      t = 0;
      while ((u_if.S_AXI_AWVALID || u_if.S_AXI_WVALID) && t < 20) begin
         aw_hs = u_if.S_AXI_AWVALID && u_if.S_AXI_AWREADY;
         w_hs  = u_if.S_AXI_WVALID && u_if.S_AXI_WREADY;
         step();
         t++;
         if (aw_hs) u_if.S_AXI_AWVALID = 1'b0;
         if (w_hs)  u_if.S_AXI_WVALID  = 1'b0;
      end
      chk({tag, "_hs_timeout"}, {u_if.S_AXI_AWVALID, u_if.S_AXI_WVALID}, 2'b00);
      chk({tag, "_bvalid"}, u_if.S_AXI_BVALID, 1'b1);
      chk({tag, "_bresp"}, u_if.S_AXI_BRESP, 2'b00);
      chk({tag, "_pulse"}, pulse, exp_pulse);
      u_if.S_AXI_BREADY = 1'b1;
      step();
      u_if.S_AXI_BREADY = 1'b0;
      chk({tag, "_bvalid_clr"}, u_if.S_AXI_BVALID, 1'b0);
      chk({tag, "_pulse_clr"}, pulse, 4'b0000);
   endtask

   task automatic do_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
      int   t;
      logic ar_hs;
      u_if.S_AXI_ARADDR  = a;
      u_if.S_AXI_ARVALID = 1'b1;
      t = 0;
      while (u_if.S_AXI_ARVALID && t < 20) begin
         ar_hs = u_if.S_AXI_ARREADY;
         step();
         t++;
         if (ar_hs) u_if.S_AXI_ARVALID = 1'b0;
      end
      chk({tag, "_ar_timeout"}, u_if.S_AXI_ARVALID, 1'b0);
      chk({tag, "_rvalid"}, u_if.S_AXI_RVALID, 1'b1);
      chk({tag, "_rdata"}, u_if.S_AXI_RDATA, exp);
      chk({tag, "_rresp"}, u_if.S_AXI_RRESP, 2'b00);
      u_if.S_AXI_RREADY = 1'b1;
      step();
      u_if.S_AXI_RREADY = 1'b0;
      chk({tag, "_rvalid_clr"}, u_if.S_AXI_RVALID, 1'b0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      u_if.S_AXI_AWADDR  = '0;
      u_if.S_AXI_AWPROT  = '0;
      u_if.S_AXI_AWVALID = 1'b0;
      u_if.S_AXI_WDATA   = '0;
      u_if.S_AXI_WSTRB   = '0;
      u_if.S_AXI_WVALID  = 1'b0;
      u_if.S_AXI_BREADY  = 1'b0;
      u_if.S_AXI_ARADDR  = '0;
      u_if.S_AXI_ARPROT  = '0;
      u_if.S_AXI_ARVALID = 1'b0;
      u_if.S_AXI_RREADY  = 1'b0;

      // Reset state
      step();
      step();
      chk("rst_regs", regs, 128'h0);
      chk("rst_pulse", pulse, 4'h0);
      chk("rst_readys", {u_if.S_AXI_AWREADY, u_if.S_AXI_WREADY, u_if.S_AXI_ARREADY}, 3'b000);
      chk("rst_valids", {u_if.S_AXI_BVALID, u_if.S_AXI_RVALID}, 2'b00);
      chk("rst_rdata", u_if.S_AXI_RDATA, 32'h0);
      rst_n = 1'b1;
      chk("rel_readys_low", {u_if.S_AXI_AWREADY, u_if.S_AXI_WREADY, u_if.S_AXI_ARREADY}, 3'b000);
      step();
      chk("rel_readys_high", {u_if.S_AXI_AWREADY, u_if.S_AXI_WREADY, u_if.S_AXI_ARREADY},
          3'b111);

      // Sequential write / readback
      do_write("w0", 4'h0, 32'h1, 4'hF);
      do_write("w1", 4'h4, 32'h2, 4'hF);
      do_write("w2", 4'h8, 32'h3, 4'hF);
      do_write("w3", 4'hC, 32'h4, 4'hF);
      chk("regs_seq", regs, 128'h00000004_00000003_00000002_00000001);
      do_read("r0", 4'h0, 32'h1);
      do_read("r1", 4'h4, 32'h2);
      do_read("r2", 4'h8, 32'h3);
      do_read("r3", 4'hC, 32'h4);

      // Byte strobes
      do_write("strb_full", 4'h4, 32'hFFFFFFFF, 4'hF);
      do_write("strb_part", 4'h4, 32'h12345678, 4'b0101);
      do_read("strb_rd", 4'h4, 32'hFF34FF78);

      // AW three cycles ahead of W, address 0x9 -> reg2
      u_if.S_AXI_AWADDR  = 4'h9;
      u_if.S_AXI_AWVALID = 1'b1;
      step();
      u_if.S_AXI_AWVALID = 1'b0;
      chk("split_aw_bvalid", u_if.S_AXI_BVALID, 1'b0);
      chk("split_aw_readys", {u_if.S_AXI_AWREADY, u_if.S_AXI_WREADY}, 2'b01);
      step();
      step();
      u_if.S_AXI_WDATA  = 32'hCAFEF00D;
      u_if.S_AXI_WSTRB  = 4'hF;
      u_if.S_AXI_WVALID = 1'b1;
      step();
      u_if.S_AXI_WVALID = 1'b0;
      chk("split_aw_commit", u_if.S_AXI_BVALID, 1'b1);
      chk("split_aw_reg2", regs[95:64], 32'hCAFEF00D);
      chk("split_aw_pulse", pulse, 4'b0100);
      u_if.S_AXI_BREADY = 1'b1;
      step();
      u_if.S_AXI_BREADY = 1'b0;

      // W three cycles ahead of AW, address 0xB -> reg2
      u_if.S_AXI_WDATA  = 32'h13579BDF;
      u_if.S_AXI_WVALID = 1'b1;
      step();
      u_if.S_AXI_WVALID = 1'b0;
      chk("split_w_bvalid", u_if.S_AXI_BVALID, 1'b0);
      chk("split_w_readys", {u_if.S_AXI_AWREADY, u_if.S_AXI_WREADY}, 2'b10);
      step();
      step();
      u_if.S_AXI_AWADDR  = 4'hB;
      u_if.S_AXI_AWVALID = 1'b1;
      step();
      u_if.S_AXI_AWVALID = 1'b0;
      chk("split_w_commit", u_if.S_AXI_BVALID, 1'b1);
      chk("split_w_reg2", regs[95:64], 32'h13579BDF);
      u_if.S_AXI_BREADY = 1'b1;
      step();
      u_if.S_AXI_BREADY = 1'b0;

      // Write response back-pressure with a second AW waiting
      u_if.S_AXI_AWADDR  = 4'hC;
      u_if.S_AXI_WDATA   = 32'hDEADBEEF;
      u_if.S_AXI_WSTRB   = 4'hF;
      u_if.S_AXI_AWVALID = 1'b1;
      u_if.S_AXI_WVALID  = 1'b1;
      step();
      u_if.S_AXI_WVALID  = 1'b0;
      u_if.S_AXI_AWADDR  = 4'h0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_b_bvalid", u_if.S_AXI_BVALID, 1'b1);
         chk("bp_b_readys", {u_if.S_AXI_AWREADY, u_if.S_AXI_WREADY}, 2'b00);
         step();
      end
      u_if.S_AXI_AWVALID = 1'b0;
      chk("bp_b_reg3", regs[127:96], 32'hDEADBEEF);
      u_if.S_AXI_BREADY = 1'b1;
      step();
      u_if.S_AXI_BREADY = 1'b0;
      chk("bp_b_release", {u_if.S_AXI_BVALID, u_if.S_AXI_AWREADY}, 2'b01);
      step();
      chk("bp_b_no_2nd_aw", {u_if.S_AXI_BVALID, u_if.S_AXI_AWREADY}, 2'b01);

      // Read data back-pressure
      u_if.S_AXI_ARADDR  = 4'hC;
      u_if.S_AXI_ARVALID = 1'b1;
      step();
      u_if.S_AXI_ARVALID = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_r_rvalid", u_if.S_AXI_RVALID, 1'b1);
         chk("bp_r_rdata", u_if.S_AXI_RDATA, 32'hDEADBEEF);
         chk("bp_r_arready", u_if.S_AXI_ARREADY, 1'b0);
         step();
      end
      u_if.S_AXI_RREADY = 1'b1;
      step();
      u_if.S_AXI_RREADY = 1'b0;
      chk("bp_r_release", {u_if.S_AXI_RVALID, u_if.S_AXI_ARREADY}, 2'b01);
      chk("bp_r_rdata_hold", u_if.S_AXI_RDATA, 32'hDEADBEEF);

      // Read and write to reg0 on the same edge
      do_write("sim_pre", 4'h0, 32'hAAAA5555, 4'hF);
      u_if.S_AXI_AWADDR  = 4'h0;
      u_if.S_AXI_WDATA   = 32'h0F0F0F0F;
      u_if.S_AXI_WSTRB   = 4'hF;
      u_if.S_AXI_ARADDR  = 4'h0;
      u_if.S_AXI_AWVALID = 1'b1;
      u_if.S_AXI_WVALID  = 1'b1;
      u_if.S_AXI_ARVALID = 1'b1;
      step();
      u_if.S_AXI_AWVALID = 1'b0;
      u_if.S_AXI_WVALID  = 1'b0;
      u_if.S_AXI_ARVALID = 1'b0;
      chk("sim_valids", {u_if.S_AXI_BVALID, u_if.S_AXI_RVALID}, 2'b11);
      chk("sim_rdata_old", u_if.S_AXI_RDATA, 32'hAAAA5555);
      chk("sim_reg0_new", regs[31:0], 32'h0F0F0F0F);
      u_if.S_AXI_BREADY = 1'b1;
      u_if.S_AXI_RREADY = 1'b1;
      step();
      u_if.S_AXI_BREADY = 1'b0;
      u_if.S_AXI_RREADY = 1'b0;
      do_read("sim_after", 4'h0, 32'h0F0F0F0F);

      // Reset after AW accepted, before W
      u_if.S_AXI_AWADDR  = 4'h4;
      u_if.S_AXI_AWVALID = 1'b1;
      step();
      u_if.S_AXI_AWVALID = 1'b0;
      chk("mid_aw_held", u_if.S_AXI_AWREADY, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_regs", regs, 128'h0);
      chk("mid_rst_outs", {u_if.S_AXI_AWREADY, u_if.S_AXI_WREADY, u_if.S_AXI_ARREADY,
                           u_if.S_AXI_BVALID, u_if.S_AXI_RVALID, pulse}, 9'h0);
      chk("mid_rst_rdata", u_if.S_AXI_RDATA, 32'h0);
      step();
      step();
      rst_n = 1'b1;
      chk("mid_rel_readys_low", {u_if.S_AXI_AWREADY, u_if.S_AXI_WREADY, u_if.S_AXI_ARREADY},
          3'b000);
      step();
      chk("mid_rel_readys_high", {u_if.S_AXI_AWREADY, u_if.S_AXI_WREADY, u_if.S_AXI_ARREADY},
          3'b111);
      chk("mid_rel_bvalid", u_if.S_AXI_BVALID, 1'b0);
      // The discarded AW must not pair with a fresh W
      u_if.S_AXI_WDATA  = 32'h5;
      u_if.S_AXI_WSTRB  = 4'hF;
      u_if.S_AXI_WVALID = 1'b1;
      step();
      u_if.S_AXI_WVALID = 1'b0;
      chk("mid_no_stale_aw", {u_if.S_AXI_BVALID, u_if.S_AXI_AWREADY}, 2'b01);
      u_if.S_AXI_AWADDR  = 4'h8;
      u_if.S_AXI_AWVALID = 1'b1;
      step();
      u_if.S_AXI_AWVALID = 1'b0;
      chk("mid_post_commit", u_if.S_AXI_BVALID, 1'b1);
      chk("mid_post_regs", regs, 128'h00000000_00000005_00000000_00000000);
      u_if.S_AXI_BREADY = 1'b1;
      step();
      u_if.S_AXI_BREADY = 1'b0;
      do_read("mid_rd_reg1", 4'h4, 32'h0);
      do_read("mid_rd_reg0", 4'h0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
